// File: rtl/staging_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry staged output register.
// Accepted operands are thresholded and shifted before being held for the consumer.
//
// state    | meaning
// ST_EMPTY | output register holds nothing, out_valid=0
// ST_FULL  | output register holds a result, out_valid=1
module staging_arbiter #(
  parameter logic [31:0] THRESHOLD = 32'd100,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_id;
  logic [CNT_W-1:0] r_xfer_count;

  logic        w_slot_free;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  logic        w_sel_id;
  logic [31:0] w_sel_data;
  logic [31:0] w_staged;

  // A contended grant goes to whichever requester was not served last.
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_gnt0      = req0_valid && (!req1_valid || r_last_grant);
    w_gnt1      = req1_valid && (!req0_valid || !r_last_grant);
    req0_ready  = !reset && w_slot_free && w_gnt0;
    req1_ready  = !reset && w_slot_free && w_gnt1;
    w_accept    = req0_ready || req1_ready;
    w_sel_id    = req1_ready;
    w_sel_data  = req1_ready ? req1_data : req0_data;
    w_staged    = (w_sel_data > THRESHOLD) ? {16'd1, w_sel_data[31:16]}
                                           : {16'd1, 16'd0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= 32'd0;
      r_out_id     <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      if (r_out_valid && out_ready)
        r_xfer_count <= r_xfer_count + CNT_W'(1);
      if (w_accept) begin
        r_last_grant <= w_sel_id;
        r_out_data   <= w_staged;
        r_out_id     <= w_sel_id;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready && !w_accept) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign xfer_count = r_xfer_count;

endmodule

// File: doc/staging_arbiter.md
STAGING_ARBITER -- requirements
Module: staging_arbiter

Interface
REQ-001 Parameter THRESHOLD, default 32'd100, unsigned compare limit for the staging transform.
REQ-002 Parameter CNT_W, default 16, width of the transfer counter.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has data.
REQ-006 req0_data  input  32  requester 0 operand.
REQ-007 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has data.
REQ-009 req1_data  input  32  requester 1 operand.
REQ-010 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-011 out_valid  output  1  staged result held in output register.
REQ-012 out_data  output  32  staged result.
REQ-013 out_id  output  1  requester that produced out_data.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 xfer_count  output  CNT_W  completed output transfers, wraps modulo 2^CNT_W.

Function
REQ-016 Handshakes: transfer occurs when valid && ready are high at the same posedge.
REQ-017 Slot free = !out_valid || out_ready; this signal is evaluated combinationally.
REQ-018 At most one of req0_ready and req1_ready is high in any cycle.
REQ-019 req*_ready is asserted only when the slot is free and that requester holds the grant.
REQ-020 Arbitration is round-robin: the requester other than last_grant wins when both are valid; a lone valid requester wins.
REQ-021 last_grant updates only on an accepted request; its value after reset is 1, so requester 0 wins the first contention.
REQ-022 Transform: data > THRESHOLD (unsigned) -> {16'd1, data[31:16]}; else -> {16'd1, 16'd0}; data == THRESHOLD takes the else branch.
REQ-023 Latency: an operand accepted at edge N is visible on out_valid/out_data/out_id after edge N, one cycle, with no bubble.
REQ-024 Back-to-back: with out_ready=1 and continuous requests, one result is produced every cycle, alternating ids.
REQ-025 Stall: with out_valid=1 and out_ready=0, out_data and out_id hold stable and both req*_ready are 0.
REQ-026 Simultaneous drain and accept in the same cycle: the new result replaces the old one, and out_valid stays 1.
REQ-027 Drain with no accept: out_valid falls to 0 at the next edge.
REQ-028 FSM states:
- EMPTY (out_valid=0); EMPTY -> FULL on accept.
- FULL (out_valid=1); FULL -> EMPTY on out_ready && no accept.
- FULL -> FULL on stall or on drain+accept.
REQ-029 xfer_count increments by 1 on each out_valid && out_ready edge.
REQ-030 xfer_count wraps from all-ones to 0 without flag or stall.
REQ-031 req*_data is sampled only on the accepting edge; later changes do not affect out_data.

Reset
REQ-032 While reset is high at a posedge, all registers take their reset values:
- out_valid=0, out_data=32'd0, out_id=0.
- xfer_count=0, last_grant=1, FSM=EMPTY.
REQ-033 While reset is high, req0_ready and req1_ready are 0 regardless of other inputs.
REQ-034 Reset mid-operation discards any held result with no output handshake; xfer_count does not count it.
REQ-035 The first accept can occur on the first posedge after reset deasserts.

Verification
REQ-036 Reset, then req0_valid=1, data=32'h00C8_0000, out_ready=1 -> next cycle out_valid=1, out_data=32'h0001_00C8, out_id=0, xfer_count=1 one edge later.
REQ-037 Boundaries with req1: data=32'd100 -> 32'h0001_0000; data=32'd101 -> 32'h0001_0000; data=32'hFFFF_1234 -> 32'h0001_FFFF.
REQ-038 Both valid continuously, out_ready=1 for 6 cycles -> ids 0,1,0,1,0,1, and never both readys high.
REQ-039 out_ready=0 for 5 cycles with both valid -> out_data/out_id constant, both readys 0; on out_ready=1 the drain+accept happens in the same cycle.
REQ-040 CNT_W=4, 17 transfers -> xfer_count reads 1; reset asserted while FULL -> out_valid=0 next cycle, xfer_count=0.
